pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3: tracked in-flight stages after ID (index 0 = EX, NUM_STAGES-1 = WB); legal 1..4.
REQ-002 SHALL have parameter REG_ADDR_W, default 5: register address width.
REQ-003 SHALL have parameter FWD_EN, default 1: 1 = forward-and-stall mode, 0 = stall-only mode.
REQ-004 SHALL have parameter CNT_W, default 32: performance counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 id_valid  in  1  ID stage holds a real instruction.
REQ-009 id_rs1_addr, id_rs2_addr  in  REG_ADDR_W each  ID source register addresses.
REQ-010 id_rs1_used, id_rs2_used  in  1 each  source operand actually read.
REQ-011 id_rd_addr  in  REG_ADDR_W  ID destination register.
REQ-012 id_rd_wen  in  1  ID instruction writes rd.
REQ-013 id_is_load  in  1  ID instruction is a load; data is available at the end of stage 1.
REQ-014 ex_jump_flag  in  1  EX resolved a taken branch/jump this cycle.
REQ-015 stall_if  out  1  hold PC.
REQ-016 stall_id  out  1  hold IF/ID and insert a bubble into EX.
REQ-017 flush_id  out  1  squash IF/ID.
REQ-018 flush_ex  out  1  insert a bubble into ID/EX.
REQ-019 fwd_sel_rs1, fwd_sel_rs2  out  FW = $clog2(NUM_STAGES+1) each  0 = register file, k = forward from stage k-1.
REQ-020 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-021 SHALL keep a tracking shift register of NUM_STAGES entries {valid, rd, wen, is_load}.
REQ-022 Each clock, entry[k] SHALL load entry[k-1] for k >= 1.
REQ-023 Each clock, entry[0] SHALL load the ID fields when id_valid && !stall_id && !flush_ex; otherwise it SHALL load a bubble (valid = 0).
REQ-024 A source SHALL be hazard-checked only if used && addr != 0.
REQ-025 A source matches entry[k] iff entry[k].valid && wen && rd == addr; the youngest (lowest k) match SHALL win.
REQ-026 FWD_EN = 0: any match on either source SHALL assert stall_id and stall_if; fwd_sel SHALL stay 0.
REQ-027 FWD_EN = 1: a youngest match at k = 0 with is_load set SHALL stall (load-use, exactly 1 cycle, then forwards from stage 1).
REQ-028 FWD_EN = 1, any other match: fwd_sel SHALL be k+1 with no stall; no match gives fwd_sel = 0.
REQ-029 NUM_STAGES = 1 with FWD_EN = 1 and a load match: the stall SHALL still resolve after 1 cycle (register file path).
REQ-030 ex_jump_flag SHALL assert flush_id and flush_ex in the same cycle, combinationally.
REQ-031 ex_jump_flag SHALL force stall_id = stall_if = 0, overriding any hazard.
REQ-032 Stall, flush, and fwd_sel outputs SHALL be combinational from tracking state and inputs; zero added latency.
REQ-033 When !id_valid, stall outputs SHALL be 0 and fwd_sel outputs SHALL be 0.
REQ-034 stall_cnt SHALL increment on each clock with stall_id = 1; flush_cnt SHALL increment on each clock with ex_jump_flag = 1.
REQ-035 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-036 Reset SHALL clear all tracking entries to invalid and both counters to 0, asynchronously.
REQ-037 While reset = 1, all stall/flush outputs SHALL be 0 and fwd_sel outputs SHALL be 0.
REQ-038 Reset asserted mid-stall SHALL drop stall_id immediately; the first cycle after release SHALL see no hazards.

Verification
REQ-039 FWD_EN = 1: ID "x5 = ..." (rd = 5, wen), then ID reads rs1 = 5 -> fwd_sel_rs1 = 1, no stall; one cycle later fwd_sel_rs1 = 2.
REQ-040 FWD_EN = 1: load rd = 7, then consumer rs2 = 7 -> stall_id = 1 for exactly 1 cycle, then fwd_sel_rs2 = 2; stall_cnt = 1.
REQ-041 FWD_EN = 0, NUM_STAGES = 3: writer rd = 3, then reader rs1 = 3 -> stall_id = 1 for 3 cycles, then 0; stall_cnt = 3.
REQ-042 Hazard stall concurrent with ex_jump_flag = 1 -> stall_id = 0, flush_id = flush_ex = 1; next cycle entry[0] is invalid; flush_cnt = 1.
REQ-043 Reader rs1 = 0 behind writer rd = 0 -> no stall, fwd_sel_rs1 = 0; two writers to rd = 9 in flight -> fwd_sel selects the younger (1).
REQ-044 CNT_W = 4, 20 consecutive stall cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: in-flight rd tracking driving forward selects, load-use/RAW stalls, jump flushes and saturating stall/flush counters
module pipe_hazard_unit #(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   id_valid,
  input  logic [REG_ADDR_W-1:0]                  id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]                  id_rs2_addr,
  input  logic                                   id_rs1_used,
  input  logic                                   id_rs2_used,
  input  logic [REG_ADDR_W-1:0]                  id_rd_addr,
  input  logic                                   id_rd_wen,
  input  logic                                   id_is_load,
  input  logic                                   ex_jump_flag,
  output logic                                   stall_if,
  output logic                                   stall_id,
  output logic                                   flush_id,
  output logic                                   flush_ex,
  output logic [$clog2(NUM_STAGES+1)-1:0]        fwd_sel_rs1,
  output logic [$clog2(NUM_STAGES+1)-1:0]        fwd_sel_rs2,
  output logic [CNT_W-1:0]                       stall_cnt,
  output logic [CNT_W-1:0]                       flush_cnt
);
  localparam int FW = $clog2(NUM_STAGES + 1);
  logic [NUM_STAGES-1:0] e_valid, e_wen, e_ld;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] e_rd;
  logic [1:0][REG_ADDR_W-1:0] src_addr;
  logic [1:0] src_used, src_hit, src_lu;
  logic [1:0][FW-1:0] src_k;
  logic hazard, sel_on;
  assign src_addr = {id_rs2_addr, id_rs1_addr};
  assign src_used = {id_rs2_used, id_rs1_used};
  always_comb begin
    src_hit = '0;
    src_lu = '0;
    src_k = '0;
    for (int s = 0; s < 2; s++)
      for (int k = NUM_STAGES - 1; k >= 0; k--)
        if (src_used[s] && src_addr[s] != '0 && e_valid[k] && e_wen[k] && e_rd[k] == src_addr[s]) begin
          src_hit[s] = 1'b1;
          src_lu[s] = k == 0 && e_ld[k];
          src_k[s] = FW'(k + 1);
        end
  end
  assign hazard = FWD_EN == 0 ? |src_hit : |src_lu;
  assign stall_id = !reset && id_valid && !ex_jump_flag && hazard;
  assign stall_if = stall_id;
  assign flush_id = !reset && ex_jump_flag;
  assign flush_ex = flush_id;
  assign sel_on = FWD_EN != 0 && !reset && id_valid;
  assign fwd_sel_rs1 = (sel_on && src_hit[0] && !src_lu[0]) ? src_k[0] : '0;
  assign fwd_sel_rs2 = (sel_on && src_hit[1] && !src_lu[1]) ? src_k[1] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      e_valid <= '0;
      e_wen <= '0;
      e_ld <= '0;
      e_rd <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      e_valid[0] <= id_valid && !stall_id && !flush_ex;
      e_wen[0] <= id_rd_wen;
      e_ld[0] <= id_is_load;
      e_rd[0] <= id_rd_addr;
      for (int k = 1; k < NUM_STAGES; k++) begin
        e_valid[k] <= e_valid[k-1];
        e_wen[k] <= e_wen[k-1];
        e_ld[k] <= e_ld[k-1];
        e_rd[k] <= e_rd[k-1];
      end
      if (stall_id && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_jump_flag && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: three configurations of the hazard unit driven in lockstep and checked against an in-flight instruction model
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  logic rst, id_valid, u1, u2, wen, ld, jump;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] sif, sid, fid, fex;
  logic [1:0] a1, a2, z1, z2;
  logic b1, b2;
  logic [31:0] c1s, c1f;
  logic [3:0] c0s, c0f, cns, cnf;
  int g_sel1[3], g_sel2[3];
  longint g_scnt[3], g_fcnt[3];
  always #5 clk = ~clk;
  assign g_sel1[0] = int'(a1);
  assign g_sel1[1] = int'(z1);
  assign g_sel1[2] = int'(b1);
  assign g_sel2[0] = int'(a2);
  assign g_sel2[1] = int'(z2);
  assign g_sel2[2] = int'(b2);
  assign g_scnt[0] = longint'(c1s);
  assign g_scnt[1] = longint'(c0s);
  assign g_scnt[2] = longint'(cns);
  assign g_fcnt[0] = longint'(c1f);
  assign g_fcnt[1] = longint'(c0f);
  assign g_fcnt[2] = longint'(cnf);
  pipe_hazard_unit dut (
    .clk(clk), .reset(rst), .id_valid(id_valid), .id_rs1_addr(rs1), .id_rs2_addr(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2), .id_rd_addr(rd), .id_rd_wen(wen), .id_is_load(ld),
    .ex_jump_flag(jump), .stall_if(sif[0]), .stall_id(sid[0]), .flush_id(fid[0]), .flush_ex(fex[0]),
    .fwd_sel_rs1(a1), .fwd_sel_rs2(a2), .stall_cnt(c1s), .flush_cnt(c1f));
  pipe_hazard_unit #(.FWD_EN(0), .CNT_W(4)) dut_stall (
    .clk(clk), .reset(rst), .id_valid(id_valid), .id_rs1_addr(rs1), .id_rs2_addr(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2), .id_rd_addr(rd), .id_rd_wen(wen), .id_is_load(ld),
    .ex_jump_flag(jump), .stall_if(sif[1]), .stall_id(sid[1]), .flush_id(fid[1]), .flush_ex(fex[1]),
    .fwd_sel_rs1(z1), .fwd_sel_rs2(z2), .stall_cnt(c0s), .flush_cnt(c0f));
  pipe_hazard_unit #(.NUM_STAGES(1), .CNT_W(4)) dut_short (
    .clk(clk), .reset(rst), .id_valid(id_valid), .id_rs1_addr(rs1), .id_rs2_addr(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2), .id_rd_addr(rd), .id_rd_wen(wen), .id_is_load(ld),
    .ex_jump_flag(jump), .stall_if(sif[2]), .stall_id(sid[2]), .flush_id(fid[2]), .flush_ex(fex[2]),
    .fwd_sel_rs1(b1), .fwd_sel_rs2(b2), .stall_cnt(cns), .flush_cnt(cnf));
  typedef struct {bit v; int rd; bit w; bit ld;} ins_t;
  ins_t pipe[3][4];
  int nst[3] = '{3, 3, 1};
  int fen[3] = '{1, 0, 1};
  longint cmax[3] = '{64'd4294967295, 64'd15, 64'd15};
  longint m_scnt[3], m_fcnt[3];
  bit e_stall[3];
  int e_sel1[3], e_sel2[3];
  int n_tests = 0, n_fail = 0;
  function automatic int youngest(int i, bit used, int a);
    if (!used || a == 0) return -1;
    for (int k = 0; k < nst[i]; k++)
      if (pipe[i][k].v && pipe[i][k].w && pipe[i][k].rd == a) return k;
    return -1;
  endfunction
  function automatic bit haz(int i, int k);
    return k >= 0 && (fen[i] == 0 || (k == 0 && pipe[i][0].ld));
  endfunction
  function automatic int sel(int i, int k);
    return (fen[i] != 0 && k >= 0 && !haz(i, k)) ? k + 1 : 0;
  endfunction
  function automatic void eval();
    for (int i = 0; i < 3; i++) begin
      int k1 = youngest(i, u1, int'(rs1));
      int k2 = youngest(i, u2, int'(rs2));
      bit on = !rst && id_valid;
      e_stall[i] = on && !jump && (haz(i, k1) || haz(i, k2));
      e_sel1[i] = on ? sel(i, k1) : 0;
      e_sel2[i] = on ? sel(i, k2) : 0;
    end
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_scnt[i] = 0;
      m_fcnt[i] = 0;
      for (int k = 0; k < 4; k++) pipe[i][k] = '{0, 0, 0, 0};
    end
  endtask
  task automatic model_update();
    eval();
    if (rst) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (e_stall[i]) m_scnt[i] = m_scnt[i] < cmax[i] ? m_scnt[i] + 1 : cmax[i];
      if (jump) m_fcnt[i] = m_fcnt[i] < cmax[i] ? m_fcnt[i] + 1 : cmax[i];
      for (int k = nst[i] - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
      pipe[i][0] = '{id_valid && !e_stall[i] && !jump, int'(rd), wen, ld};
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic set_id(bit v, int r1, bit s1, int r2, bit s2, int d, bit w, bit l);
    id_valid = v; rs1 = 5'(r1); u1 = s1; rs2 = 5'(r2); u2 = s2; rd = 5'(d); wen = w; ld = l;
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    jump = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    jump = 1'b1;
    set_id(1, 1, 1, 1, 1, 1, 1, 1);
    model_clear();
    #2;
    for (int i = 0; i < 3; i++) begin
      if ({sif[i], sid[i], fid[i], fex[i]} !== 4'b0) begin
        $display("FAIL reset_ctl inst%0d: got %b want 0000", i, {sif[i], sid[i], fid[i], fex[i]});
        n_fail++;
      end
      n_tests++;
      if (g_sel1[i] !== 0 || g_sel2[i] !== 0 || g_scnt[i] !== 0 || g_fcnt[i] !== 0) begin
        $display("FAIL reset_sel_cnt inst%0d: got sel %0d/%0d cnt %0d/%0d want all 0", i, g_sel1[i], g_sel2[i], g_scnt[i], g_fcnt[i]);
        n_fail++;
      end
      n_tests++;
    end
    tick();
    jump = 1'b0;
    rst = 1'b0;
    #1;
    if (c1s !== 32'd0 || c1f !== 32'd0) begin
      $display("FAIL reset_release: got cnt %0d/%0d want 0/0", c1s, c1f);
      n_fail++;
    end
    n_tests++;
  endtask
  task automatic test_forward();
    apply_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    #1;
    if (a1 !== 2'd1 || sid[0] !== 1'b0) begin
      $display("FAIL fwd_ex: got sel %0d stall %0d want sel 1 stall 0", a1, sid[0]);
      n_fail++;
    end
    n_tests++;
    tick();
    #1;
    if (a1 !== 2'd2 || sid[0] !== 1'b0) begin
      $display("FAIL fwd_mem: got sel %0d stall %0d want sel 2 stall 0", a1, sid[0]);
      n_fail++;
    end
    n_tests++;
    tick();
  endtask
  task automatic test_load_use();
    apply_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 0, 0, 7, 1, 0, 0, 0);
    #1;
    if (sid[0] !== 1'b1 || sif[0] !== 1'b1 || sid[2] !== 1'b1) begin
      $display("FAIL load_use_stall: got stall_id %0d stall_if %0d short %0d want 1 1 1", sid[0], sif[0], sid[2]);
      n_fail++;
    end
    n_tests++;
    tick();
    #1;
    if (sid[0] !== 1'b0 || a2 !== 2'd2 || c1s !== 32'd1) begin
      $display("FAIL load_use_after: got stall %0d sel %0d cnt %0d want 0 2 1", sid[0], a2, c1s);
      n_fail++;
    end
    n_tests++;
    if (sid[2] !== 1'b0 || b2 !== 1'b0 || cns !== 4'd1) begin
      $display("FAIL load_use_short: got stall %0d sel %0d cnt %0d want 0 0 1", sid[2], b2, cns);
      n_fail++;
    end
    n_tests++;
    tick();
  endtask
  task automatic test_stall_only();
    apply_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    set_id(1, 3, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (sid[1] !== 1'b1 || z1 !== 2'd0) begin
        $display("FAIL stall_only_cyc%0d: got stall %0d sel %0d want 1 0", c, sid[1], z1);
        n_fail++;
      end
      n_tests++;
      tick();
    end
    #1;
    if (sid[1] !== 1'b0 || c0s !== 4'd3) begin
      $display("FAIL stall_only_end: got stall %0d cnt %0d want 0 3", sid[1], c0s);
      n_fail++;
    end
    n_tests++;
    tick();
  endtask
  task automatic test_jump();
    apply_reset();
    set_id(1, 0, 0, 0, 0, 4, 1, 1);
    tick();
    set_id(1, 4, 1, 0, 0, 8, 1, 0);
    jump = 1'b1;
    #1;
    if ({sid[0], sif[0], fid[0], fex[0], sid[1]} !== 5'b00110) begin
      $display("FAIL jump_override: got %b want 00110", {sid[0], sif[0], fid[0], fex[0], sid[1]});
      n_fail++;
    end
    n_tests++;
    tick();
    jump = 1'b0;
    set_id(1, 8, 1, 0, 0, 0, 0, 0);
    #1;
    if (a1 !== 2'd0 || sid[1] !== 1'b0) begin
      $display("FAIL jump_bubble: got sel %0d stall %0d want 0 0", a1, sid[1]);
      n_fail++;
    end
    n_tests++;
    if (c1f !== 32'd1 || c1s !== 32'd0) begin
      $display("FAIL jump_cnt: got flush %0d stall %0d want 1 0", c1f, c1s);
      n_fail++;
    end
    n_tests++;
    tick();
  endtask
  task automatic test_zero_youngest();
    apply_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 1, 0, 1, 0, 0, 0);
    #1;
    if (sid[1] !== 1'b0 || a1 !== 2'd0) begin
      $display("FAIL x0_reader: got stall %0d sel %0d want 0 0", sid[1], a1);
      n_fail++;
    end
    n_tests++;
    tick();
    set_id(1, 0, 0, 0, 0, 9, 1, 0);
    tick();
    tick();
    set_id(1, 9, 1, 0, 0, 0, 0, 0);
    #1;
    if (a1 !== 2'd1) begin
      $display("FAIL youngest_wins: got sel %0d want 1", a1);
      n_fail++;
    end
    n_tests++;
    tick();
  endtask
  task automatic test_saturate();
    apply_reset();
    for (int p = 0; p < 8; p++) begin
      set_id(1, 0, 0, 0, 0, 3, 1, 0);
      tick();
      set_id(1, 3, 1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 10; c++) begin
        #1;
        eval();
        if (sid[1] !== e_stall[1]) begin
          $display("FAIL sat_stall p%0d c%0d: got %0d want %0d", p, c, sid[1], e_stall[1]);
          n_fail++;
        end
        n_tests++;
        if (!e_stall[1]) break;
        tick();
      end
      tick();
    end
    if (c0s !== 4'd15) begin
      $display("FAIL stall_cnt_sat: got %0d want 15", c0s);
      n_fail++;
    end
    n_tests++;
  endtask
  task automatic test_reset_mid_stall();
    apply_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 0, 0, 7, 1, 0, 0, 0);
    #1;
    if (sid[0] !== 1'b1) begin
      $display("FAIL pre_reset_stall: got %0d want 1", sid[0]);
      n_fail++;
    end
    n_tests++;
    rst = 1'b1;
    model_clear();
    #1;
    if (sid[0] !== 1'b0 || c1s !== 32'd0) begin
      $display("FAIL reset_drops_stall: got stall %0d cnt %0d want 0 0", sid[0], c1s);
      n_fail++;
    end
    n_tests++;
    tick();
    rst = 1'b0;
    #1;
    if (sid[0] !== 1'b0 || a2 !== 2'd0 || sid[1] !== 1'b0) begin
      $display("FAIL post_reset_clean: got stall %0d sel %0d stall_only %0d want 0 0 0", sid[0], a2, sid[1]);
      n_fail++;
    end
    n_tests++;
    tick();
  endtask
  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 49) == 0;
      if (rst) model_clear();
      set_id($urandom_range(0, 9) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      jump = $urandom_range(0, 9) == 0;
      #1;
      eval();
      for (int i = 0; i < 3; i++) begin
        if (sid[i] !== e_stall[i] || sif[i] !== e_stall[i]) begin
          $display("FAIL rnd_stall n%0d inst%0d: got %0d/%0d want %0d", n, i, sid[i], sif[i], e_stall[i]);
          n_fail++;
        end
        n_tests++;
        if (fid[i] !== (jump && !rst) || fex[i] !== (jump && !rst)) begin
          $display("FAIL rnd_flush n%0d inst%0d: got %0d/%0d want %0d", n, i, fid[i], fex[i], jump && !rst);
          n_fail++;
        end
        n_tests++;
        if (g_sel1[i] !== e_sel1[i] || g_sel2[i] !== e_sel2[i]) begin
          $display("FAIL rnd_sel n%0d inst%0d: got %0d/%0d want %0d/%0d", n, i, g_sel1[i], g_sel2[i], e_sel1[i], e_sel2[i]);
          n_fail++;
        end
        n_tests++;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        if (g_scnt[i] !== m_scnt[i] || g_fcnt[i] !== m_fcnt[i]) begin
          $display("FAIL rnd_cnt n%0d inst%0d: got %0d/%0d want %0d/%0d", n, i, g_scnt[i], g_fcnt[i], m_scnt[i], m_fcnt[i]);
          n_fail++;
        end
        n_tests++;
      end
    end
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_stall_only();
    test_jump();
    test_zero_youngest();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
